// File: rtl/trap_sequencer_if.sv
// Trap sequencer bus: writeback requests and CSR snapshots in; CSR write port, privilege and redirect out.
interface trap_sequencer_if #(
   parameter int unsigned XLEN = 64
);
   logic            exc_valid;
   logic [5:0]      exc_code;
   logic [XLEN-1:0] exc_pc;
   logic            mret_valid;
   logic            drained;
   logic [XLEN-1:0] resume_pc;
   logic [XLEN-1:0] mstatus;
   logic [XLEN-1:0] mip;
   logic [XLEN-1:0] mie;
   logic [XLEN-1:0] mtvec;
   logic [XLEN-1:0] mepc;

   logic            flush_req;
   logic            busy;
   logic            csr_we;
   logic [11:0]     csr_addr;
   logic [XLEN-1:0] csr_wdata;
   logic [1:0]      mode;
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;

   // Pipeline / CSR-file side
   modport master (
      output exc_valid, exc_code, exc_pc, mret_valid, drained, resume_pc,
             mstatus, mip, mie, mtvec, mepc,
      input  flush_req, busy, csr_we, csr_addr, csr_wdata, mode,
             redirect_valid, redirect_pc
   );

   // Sequencer side
   modport slave (
      input  exc_valid, exc_code, exc_pc, mret_valid, drained, resume_pc,
             mstatus, mip, mie, mtvec, mepc,
      output flush_req, busy, csr_we, csr_addr, csr_wdata, mode,
             redirect_valid, redirect_pc
   );
endinterface

// File: rtl/trap_sequencer.sv
// Trap entry / mret controller: arbitrates requests, drains, writes mepc/mcause/mstatus, redirects the PC.
module trap_sequencer #(
   parameter int unsigned XLEN = 64
) (
   input logic             clk,
   input logic             rst,
   trap_sequencer_if.slave tif
);
   localparam int unsigned CODE_W   = 6;
   localparam int unsigned ADDR_W   = 12;
   localparam int unsigned PAD_W    = XLEN - 1 - CODE_W;
   localparam logic [ADDR_W-1:0] A_MEPC    = 12'h341;
   localparam logic [ADDR_W-1:0] A_MCAUSE  = 12'h342;
   localparam logic [ADDR_W-1:0] A_MSTATUS = 12'h300;
   localparam logic [XLEN-1:0]   IRQ_MASK  = XLEN'(12'h888);

   typedef enum logic [2:0] {
      S_IDLE,
      S_DRAIN,
      S_W_MEPC,
      S_W_MCAUSE,
      S_W_MSTATUS,
      S_REDIRECT
   } state_t;

   state_t              state_q, state_d;
   logic [XLEN-1:0]     pc_q, pc_d;
   logic [CODE_W-1:0]   code_q, code_d;
   logic                intr_q, intr_d;
   logic                ret_q, ret_d;
   logic [XLEN-1:0]     mst_q, mst_d;
   logic [1:0]          mode_q, mode_d;

   logic                busy_q, busy_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [XLEN-1:0]     wdata_q, wdata_d;
   logic                rv_q, rv_d;
   logic [XLEN-1:0]     rpc_q, rpc_d;

   logic [XLEN-1:0]     pend;
   logic                irq_ok;
   logic [CODE_W-1:0]   irq_code;
   logic [XLEN-1:0]     mst_wr;
   logic [XLEN-1:0]     trap_tgt;

   // Interrupt eligibility and fixed priority 11 > 3 > 7
   always_comb begin
      pend     = tif.mip & tif.mie;
      irq_ok   = ((mode_q == 2'd3 && tif.mstatus[3]) || mode_q == 2'd0) && (|(pend & IRQ_MASK));
      irq_code = CODE_W'(7);
      if (pend[11])     irq_code = CODE_W'(11);
      else if (pend[3]) irq_code = CODE_W'(3);
   end

   // Next state and latched trap context
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      code_d  = code_q;
      intr_d  = intr_q;
      ret_d   = ret_q;
      mst_d   = mst_q;
      mode_d  = mode_q;
      case (state_q)
         S_IDLE: begin
            if (tif.exc_valid) begin
               pc_d    = tif.exc_pc;
               code_d  = tif.exc_code;
               intr_d  = 1'b0;
               ret_d   = 1'b0;
               mst_d   = tif.mstatus;
               state_d = S_W_MEPC;
            end else if (tif.mret_valid) begin
               pc_d    = tif.mepc;
               mst_d   = tif.mstatus;
               ret_d   = 1'b1;
               state_d = S_W_MSTATUS;
            end else if (irq_ok) begin
               code_d  = irq_code;
               intr_d  = 1'b1;
               ret_d   = 1'b0;
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (tif.exc_valid) begin
               pc_d    = tif.exc_pc;
               code_d  = tif.exc_code;
               intr_d  = 1'b0;
               mst_d   = tif.mstatus;
               state_d = S_W_MEPC;
            end else if (tif.drained) begin
               if (irq_ok) begin
                  pc_d    = tif.resume_pc;
                  mst_d   = tif.mstatus;
                  state_d = S_W_MEPC;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         S_W_MEPC:    state_d = S_W_MCAUSE;
         S_W_MCAUSE:  state_d = S_W_MSTATUS;
         S_W_MSTATUS: begin
            mode_d  = ret_q ? mst_q[12:11] : 2'd3;
            state_d = S_REDIRECT;
         end
         S_REDIRECT:  state_d = S_IDLE;
         default:     state_d = S_IDLE;
      endcase
   end

   // New mstatus image for trap entry or return
   always_comb begin
      mst_wr = mst_d;
      if (ret_d) begin
         mst_wr[3]     = mst_d[7];
         mst_wr[7]     = 1'b1;
         mst_wr[12:11] = 2'd0;
      end else begin
         mst_wr[7]     = mst_d[3];
         mst_wr[3]     = 1'b0;
         mst_wr[12:11] = mode_q;
      end
   end

   // Trap vector: base, plus 4*code for vectored interrupts (wraps)
   always_comb begin
      trap_tgt = {tif.mtvec[XLEN-1:2], 2'b00};
      if (tif.mtvec[1:0] == 2'b01 && intr_d)
         trap_tgt = trap_tgt + XLEN'({code_d, 2'b00});
   end

   // Output values for the state being entered, registered below
   always_comb begin
      busy_d  = (state_d != S_IDLE);
      we_d    = 1'b0;
      addr_d  = '0;
      wdata_d = '0;
      rv_d    = 1'b0;
      rpc_d   = '0;
      case (state_d)
         S_W_MEPC: begin
            we_d    = 1'b1;
            addr_d  = A_MEPC;
            wdata_d = {pc_d[XLEN-1:2], 2'b00};
         end
         S_W_MCAUSE: begin
            we_d    = 1'b1;
            addr_d  = A_MCAUSE;
            wdata_d = {intr_d, {PAD_W{1'b0}}, code_d};
         end
         S_W_MSTATUS: begin
            we_d    = 1'b1;
            addr_d  = A_MSTATUS;
            wdata_d = mst_wr;
         end
         S_REDIRECT: begin
            rv_d  = 1'b1;
            rpc_d = ret_d ? pc_d : trap_tgt;
         end
         default: ;
      endcase
   end

   // State, context and output registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         pc_q    <= '0;
         code_q  <= '0;
         intr_q  <= 1'b0;
         ret_q   <= 1'b0;
         mst_q   <= '0;
         mode_q  <= 2'd3;
         busy_q  <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rv_q    <= 1'b0;
         rpc_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         code_q  <= code_d;
         intr_q  <= intr_d;
         ret_q   <= ret_d;
         mst_q   <= mst_d;
         mode_q  <= mode_d;
         busy_q  <= busy_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rv_q    <= rv_d;
         rpc_q   <= rpc_d;
      end
   end

   assign tif.busy           = busy_q;
   assign tif.flush_req      = busy_q;
   assign tif.csr_we         = we_q;
   assign tif.csr_addr       = addr_q;
   assign tif.csr_wdata      = wdata_q;
   assign tif.mode           = mode_q;
   assign tif.redirect_valid = rv_q;
   assign tif.redirect_pc    = rpc_q;
endmodule

// File: tb/tb_trap_sequencer.sv
// Directed bench for trap_sequencer: exception, vectored interrupt, priority, mret, drain corners, async reset.
module tb_trap_sequencer;
   logic clk;
   logic rst;
   int   n_tests;
   int   n_fail;
   int   we_cnt;
   int   we_snap;

   trap_sequencer_if #(.XLEN(64)) tif();

   trap_sequencer #(.XLEN(64)) dut (
      .clk (clk),
      .rst (rst),
      .tif (tif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count CSR write strobes seen by the CSR file
   always @(negedge clk) if (tif.csr_we) we_cnt = we_cnt + 1;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests = n_tests + 1;
      if (got !== exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_write(input string tag, input logic [11:0] addr, input logic [63:0] data);
      chk({tag, "_we"}, 64'(tif.csr_we), 64'd1);
      chk({tag, "_addr"}, 64'(tif.csr_addr), 64'(addr));
      chk({tag, "_data"}, tif.csr_wdata, data);
      chk({tag, "_busy"}, 64'(tif.busy), 64'd1);
   endtask

   task automatic chk_redirect(input string tag, input logic [63:0] pc, input logic [1:0] md);
      chk({tag, "_rv"}, 64'(tif.redirect_valid), 64'd1);
      chk({tag, "_rpc"}, tif.redirect_pc, pc);
      chk({tag, "_we0"}, 64'(tif.csr_we), 64'd0);
      chk({tag, "_mode"}, 64'(tif.mode), 64'(md));
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_busy0"}, 64'(tif.busy), 64'd0);
      chk({tag, "_flush0"}, 64'(tif.flush_req), 64'd0);
      chk({tag, "_rv0"}, 64'(tif.redirect_valid), 64'd0);
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      we_cnt  = 0;
      rst = 1'b0;
      tif.exc_valid  = 1'b0;
      tif.exc_code   = '0;
      tif.exc_pc     = '0;
      tif.mret_valid = 1'b0;
      tif.drained    = 1'b0;
      tif.resume_pc  = '0;
      tif.mstatus    = '0;
      tif.mip        = '0;
      tif.mie        = '0;
      tif.mtvec      = '0;
      tif.mepc       = '0;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_mode", 64'(tif.mode), 64'd3);
      chk("rst_csr_addr", 64'(tif.csr_addr), 64'd0);
      chk("rst_csr_wdata", tif.csr_wdata, 64'd0);
      chk("rst_rpc", tif.redirect_pc, 64'd0);
      chk("rst_we", 64'(tif.csr_we), 64'd0);
      chk_idle("rst");
      @(negedge clk);
      rst = 1'b1;
      step();
      chk_idle("post_rst");

      // mret: MPIE=1, MPP=0 -> mstatus 0x88, mode 0
      tif.mstatus = 64'h80;
      tif.mepc = 64'h8000_0200;
      tif.mret_valid = 1'b1;
      step();
      tif.mret_valid = 1'b0;
      chk_write("mret_mst", 12'h300, 64'h88);
      chk("mret_mode_hold", 64'(tif.mode), 64'd3);
      step();
      chk_redirect("mret_redir", 64'h8000_0200, 2'd0);
      step();
      chk_idle("mret_end");

      // Exception from U-mode, code 2
      tif.mstatus = 64'h8;
      tif.mtvec = 64'h8000_1000;
      tif.exc_code = 6'd2;
      tif.exc_pc = 64'h8000_0102;
      tif.exc_valid = 1'b1;
      step();
      tif.exc_valid = 1'b0;
      chk_write("exc_mepc", 12'h341, 64'h8000_0100);
      chk("exc_flush", 64'(tif.flush_req), 64'd1);
      step();
      chk_write("exc_mcause", 12'h342, 64'h2);
      step();
      chk_write("exc_mst", 12'h300, 64'h80);
      chk("exc_mode_hold", 64'(tif.mode), 64'd0);
      step();
      chk_redirect("exc_redir", 64'h8000_1000, 2'd3);
      step();
      chk_idle("exc_end");

      // Vectored timer interrupt, drained after 3 cycles
      tif.mstatus = 64'h8;
      tif.mip = 64'h80;
      tif.mie = 64'h80;
      tif.mtvec = 64'h8000_1001;
      step();
      for (int i = 0; i < 3; i++) begin
         chk("tmr_drain_busy", 64'(tif.busy), 64'd1);
         chk("tmr_drain_we", 64'(tif.csr_we), 64'd0);
         if (i == 2) begin
            tif.drained = 1'b1;
            tif.resume_pc = 64'h8000_0040;
         end
         step();
      end
      tif.drained = 1'b0;
      tif.mip = '0;
      tif.mie = '0;
      chk_write("tmr_mepc", 12'h341, 64'h8000_0040);
      step();
      chk_write("tmr_mcause", 12'h342, 64'h8000_0000_0000_0007);
      step();
      chk_write("tmr_mst", 12'h300, 64'h1880);
      step();
      chk_redirect("tmr_redir", 64'h8000_101C, 2'd3);
      step();
      chk_idle("tmr_end");

      // Interrupt priority: 11 wins over 3 and 7, direct mode
      tif.mtvec = 64'h8000_1000;
      tif.mip = 64'h888;
      tif.mie = 64'h888;
      step();
      tif.drained = 1'b1;
      tif.resume_pc = 64'h8000_0080;
      step();
      tif.drained = 1'b0;
      tif.mip = '0;
      tif.mie = '0;
      chk_write("pri_mepc", 12'h341, 64'h8000_0080);
      step();
      chk_write("pri_mcause", 12'h342, 64'h8000_0000_0000_000B);
      step();
      step();
      chk_redirect("pri_redir", 64'h8000_1000, 2'd3);
      step();

      // exc_valid and mret_valid together: exception path only
      tif.mstatus = 64'h0;
      tif.exc_code = 6'd3;
      tif.exc_pc = 64'h8000_0300;
      tif.mepc = 64'h8000_0200;
      tif.exc_valid = 1'b1;
      tif.mret_valid = 1'b1;
      step();
      tif.exc_valid = 1'b0;
      tif.mret_valid = 1'b0;
      chk_write("both_mepc", 12'h341, 64'h8000_0300);
      step();
      chk_write("both_mcause", 12'h342, 64'h3);
      step();
      chk_write("both_mst", 12'h300, 64'h1800);
      step();
      chk_redirect("both_redir", 64'h8000_1000, 2'd3);
      step();
      chk_idle("both_end");

      // DRAIN abort: mie cleared before drained, no CSR writes
      tif.mstatus = 64'h8;
      tif.mip = 64'h80;
      tif.mie = 64'h80;
      we_snap = we_cnt;
      step();
      tif.mie = '0;
      chk("abort_drain_busy", 64'(tif.busy), 64'd1);
      step();
      tif.drained = 1'b1;
      step();
      tif.drained = 1'b0;
      tif.mip = '0;
      chk_idle("abort_end");
      step();
      chk("abort_no_we", 64'(we_cnt), 64'(we_snap));

      // Exception during DRAIN replaces the interrupt
      tif.mtvec = 64'h8000_1001;
      tif.mip = 64'h80;
      tif.mie = 64'h80;
      step();
      tif.mip = '0;
      tif.mie = '0;
      tif.exc_code = 6'd5;
      tif.exc_pc = 64'h8000_0504;
      tif.exc_valid = 1'b1;
      step();
      tif.exc_valid = 1'b0;
      chk_write("dexc_mepc", 12'h341, 64'h8000_0504);
      step();
      chk_write("dexc_mcause", 12'h342, 64'h5);
      step();
      step();
      chk_redirect("dexc_redir", 64'h8000_1000, 2'd3);
      step();

      // Async reset during W_MCAUSE, starting from U-mode
      tif.mstatus = 64'h0;
      tif.mret_valid = 1'b1;
      step();
      tif.mret_valid = 1'b0;
      step();
      step();
      chk("ar_umode", 64'(tif.mode), 64'd0);
      tif.exc_code = 6'd2;
      tif.exc_pc = 64'h8000_0102;
      tif.exc_valid = 1'b1;
      step();
      tif.exc_valid = 1'b0;
      step();
      chk_write("ar_mcause", 12'h342, 64'h2);
      #2;
      rst = 1'b0;
      #1;
      chk("ar_we", 64'(tif.csr_we), 64'd0);
      chk("ar_addr", 64'(tif.csr_addr), 64'd0);
      chk("ar_wdata", tif.csr_wdata, 64'd0);
      chk("ar_mode", 64'(tif.mode), 64'd3);
      chk_idle("ar");
      we_snap = we_cnt;
      @(negedge clk);
      rst = 1'b1;
      repeat (4) step();
      chk("ar_no_more_we", 64'(we_cnt), 64'(we_snap));
      chk_idle("ar_after");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/trap_sequencer.md
# trap_sequencer

Multi-cycle trap-entry and trap-return controller behind the writeback stage. Arbitrates synchronous exceptions, `mret`, and pending machine interrupts, then:
- drains the pipeline;
- writes `mepc`/`mcause`/`mstatus` through the CSR write port, one register per cycle;
- updates the privilege mode;
- issues a single-cycle PC redirect to the trap vector or to `mepc`.

Writeback raises requests and stops deciding trap eligibility itself.

## Interface
- `XLEN`, 64, data/PC width
- `clk`  in  1  clock; one clock; reset is asynchronous and active-low
- `rst`  in  1  reset, asynchronous, active-low (0 = reset)
- `exc_valid`  in  1  writeback instruction raised an exception or `ecall`
- `exc_code`  in  6  exception cause code
- `exc_pc`  in  XLEN  PC of faulting instruction
- `mret_valid`  in  1  writeback instruction is `mret`
- `drained`  in  1  pipeline empty of younger instructions
- `resume_pc`  in  XLEN  PC of oldest unretired instruction (valid with `drained`)
- `mstatus`, `mip`, `mie`, `mtvec`, `mepc`  in  XLEN each  current CSR values
- `flush_req`  out  1  squash all non-committed instructions
- `busy`  out  1  sequencer not IDLE
- `csr_we`  out  1  CSR write strobe
- `csr_addr`  out  12  CSR address (`0x341` mepc, `0x342` mcause, `0x300` mstatus)
- `csr_wdata`  out  XLEN  CSR write data
- `mode`  out  2  current privilege (0 = U, 3 = M)
- `redirect_valid`  out  1  one-cycle PC redirect strobe
- `redirect_pc`  out  XLEN  redirect target

## Operation
- **States:** IDLE, DRAIN, W_MEPC, W_MCAUSE, W_MSTATUS, REDIRECT.
- **Interrupt eligible:** `(mode==3 && mstatus[3]) || mode==0`, and `(mip & mie)` has any of bits 11, 3 or 7.
  - Priority among pending bits: 11 > 3 > 7.
- **IDLE arbitration, same cycle:** `exc_valid` > `mret_valid` > interrupt.
- **Exception:** latch `exc_pc`, `exc_code` (interrupt flag = 0) and `mstatus`; go to W_MEPC.
- **mret:** latch `mstatus` and `mepc`; go to W_MSTATUS (return variant).
- **Interrupt:** latch code (interrupt flag = 1); go to DRAIN.
  - In DRAIN: on `drained`, latch `resume_pc` and `mstatus`, then go to W_MEPC.
  - In DRAIN: if `exc_valid` (an older instruction faulted), the exception replaces the interrupt and goes to W_MEPC.
  - In DRAIN: if the interrupt is no longer eligible at `drained`, return to IDLE with no CSR writes.
- **W_MEPC:** write the latched PC with bits [1:0] forced to 0.
- **W_MCAUSE:** write `{intr_flag, 0…, code}`, with `intr_flag` at bit XLEN-1.
- **W_MSTATUS, trap variant:**
  - MPIE[7] ← MIE[3]
  - MIE ← 0
  - MPP[12:11] ← `mode`
  - `mode` ← 3
- **W_MSTATUS, mret variant:**
  - MIE ← MPIE
  - MPIE ← 1
  - `mode` ← MPP
  - MPP ← 0
- **REDIRECT target:**
  - mret: the latched `mepc`.
  - trap: `{mtvec[XLEN-1:2], 2'b00}`, plus `4*code` when `mtvec[1:0]==1` and the trap is an interrupt.
  - Vector add wraps modulo 2^XLEN.
- `exc_valid`, `mret_valid` and interrupts are ignored outside IDLE, except `exc_valid` in DRAIN.

## Timing
- **Reset values:** state IDLE, `mode`=3, and all other outputs 0. Reset mid-sequence aborts immediately with no further writes.
- All outputs are registered or decoded from state only; none is combinational from inputs.
- `flush_req` = `busy` = 1 in every non-IDLE state.
- **Exception accepted at edge N:**
  - W_MEPC: N+1
  - W_MCAUSE: N+2
  - W_MSTATUS: N+3, with `mode` updated at edge N+4
  - REDIRECT: N+4
  - IDLE: N+5
- **mret accepted at edge N:** W_MSTATUS N+1, REDIRECT N+2, IDLE N+3.
- **Interrupt:** DRAIN lasts ≥1 cycle. Edge where `drained`=1 → W_MEPC on the next cycle.
- `csr_we` is high for exactly one cycle in each W_* state. `csr_addr`/`csr_wdata` are stable in that cycle.
- `redirect_valid` is high for exactly one cycle (REDIRECT).
- A new request can be accepted in the IDLE cycle immediately after REDIRECT.

## Test plan
- **Exception.** `mode`=0, `exc_valid`, code 2, `exc_pc`=0x8000_0102, `mtvec`=0x8000_1000.
  - mepc write 0x8000_0100, then mcause write 0x2, then mstatus write with MPP=0, MIE=0.
  - `mode`=3, redirect to 0x8000_1000 at N+4.
- **Vectored timer interrupt.** `mode`=3, `mstatus`=0x8, `mip`=`mie`=0x80, `mtvec`=0x8000_1001; `drained` after 3 cycles with `resume_pc`=0x8000_0040.
  - mcause=0x8000…0007, mepc=0x8000_0040, redirect 0x8000_101C.
- **Priority.**
  - `mip`=`mie`=0x888 → mcause code 11.
  - `exc_valid` and `mret_valid` in the same cycle → exception path only.
- **mret.** `mstatus`=0x80 (MPIE=1, MPP=0), `mepc`=0x8000_0200.
  - mstatus write 0x88, `mode`=0, redirect 0x8000_0200 at N+2.
- **DRAIN boundaries.**
  - `mie` cleared before `drained` → return to IDLE, `csr_we` never asserted.
  - `exc_valid` during DRAIN → exception cause written, interrupt flag 0.
- **Async reset.** Assert `rst`=0 during W_MCAUSE → all outputs 0 and `mode`=3 within the same cycle. After release, no mstatus write occurs.
